swap_sort_ctrl: RTL
===================

SWAP_SORT_CTRL -- requirements
Module: swap_sort_ctrl

Interface
REQ-001 Parameter INIT_ON_START, default 0; when 1, the register file is re-initialised before every sort.
REQ-002 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  request to sort; sampled only in IDLE.
REQ-005 Port mode  input  1  0 = ascending (r[0] smallest), 1 = descending; sampled with start and held for the whole sort.
REQ-006 Port rd_x  input  4  register-file read data at address x, combinational.
REQ-007 Port rd_y  input  4  register-file read data at address y, combinational.
REQ-008 Port init  output  1  register-file initialise strobe.
REQ-009 Port x  output  3  register-file address x.
REQ-010 Port y  output  3  register-file address y.
REQ-011 Port swap  output  1  register-file swap strobe; the exchange commits on the clock edge at which swap=1.
REQ-012 Port busy  output  1  high from the cycle after start is accepted until the DONE cycle inclusive.
REQ-013 Port done  output  1  one-cycle completion pulse.
REQ-014 Port swap_count  output  5  number of swaps in the current/last sort; range 0..28.

Function
REQ-015 The FSM SHALL have states IDLE, INIT, COMPARE, SWAP and DONE.
REQ-016 Outputs SHALL be registered/state-decoded: init=1 only in INIT, swap=1 only in SWAP, done=1 only in DONE, busy=1 in all states except IDLE.
REQ-017 Transitions from IDLE on start=1: go to INIT if INIT_ON_START=1, else to COMPARE; clear swap_count and set pass=0, i=0.
REQ-018 INIT SHALL last exactly 1 cycle and then go to COMPARE.
REQ-019 In COMPARE and SWAP, x SHALL equal i and y SHALL equal i+1; both SHALL stay stable across the COMPARE/SWAP pair.
REQ-020 In COMPARE, out-of-order is defined as rd_x>rd_y (mode 0) or rd_x<rd_y (mode 1), compared unsigned; equal values are never swapped.
REQ-021 In COMPARE, if the pair is out of order, go to SWAP; otherwise advance the index.
REQ-022 SWAP SHALL last exactly 1 cycle; it SHALL increment swap_count, set the per-pass swapped flag and then advance the index.
REQ-023 Index advance: if i<6-pass, set i=i+1 and go to COMPARE.
REQ-024 End of pass: if the swapped flag is 0 or pass=6, go to DONE; otherwise set pass=pass+1, i=0, clear the flag and go to COMPARE.
REQ-025 DONE SHALL last 1 cycle and then go to IDLE.
REQ-026 swap_count SHALL hold its value in IDLE until the next accepted start.
REQ-027 start while busy=1 SHALL be ignored; start held high continuously re-triggers a sort each time IDLE is reached.
REQ-028 Latency from the start edge to done, with INIT_ON_START=0, SHALL be 1 + (number of compares) + (number of swaps) cycles.
REQ-029 Worst case is 28 compares plus 28 swaps, giving done in cycle 57.
REQ-030 With INIT_ON_START=1, latency SHALL be one cycle more than REQ-028.

Reset
REQ-031 reset=1 SHALL force IDLE asynchronously and drive init=0, swap=0, busy=0, done=0, x=0, y=0, swap_count=0, pass=0, i=0.
REQ-032 reset mid-sort SHALL abort the sort with no swap strobe issued on or after the reset edge; register-file contents are left as partially sorted.
REQ-033 After reset deasserts, the first start is accepted at the first posedge with start=1.

Structure
REQ-034 Package sort_ctrl_pkg SHALL hold the state enum, N_REGS=8, IDX_W=3, DATA_W=4 and CNT_W=5.
REQ-035 Sub-module order_cmp (combinational: a, b, mode -> out_of_order) SHALL implement REQ-020; everything else lives in swap_sort_ctrl.

Verification
REQ-036 Scenario 1: with the bench model register file holding r=0..7, start with mode=0 -> no swap pulses, done in cycle 8, swap_count=0.
REQ-037 Scenario 2: r=0..7, start with mode=1 -> 28 swap pulses, done in cycle 57, r[k]=7-k, swap_count=28.
REQ-038 Scenario 3: r={3,3,1,1,2,2,0,0}, mode=0 -> sorted ascending, equal pairs never swapped, swap_count=20.
REQ-039 Scenario 4: reset asserted in cycle 10 of the Scenario 2 sort -> all outputs 0 in the same cycle and no further swap; a new start then completes correctly.
REQ-040 Scenario 5: start pulsed during busy -> ignored and exactly one done pulse; with INIT_ON_START=1 and r scrambled -> init high for 1 cycle, then r=0..7 restored, done in cycle 9, swap_count=0.

Source files
------------

// File: rtl/sort_ctrl_pkg.sv
// ============================================================================
// Module      : sort_ctrl_pkg
// Description : Shared sizes and FSM state encoding for the swap-sort controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sort_ctrl_pkg;

    localparam int N_REGS = 8;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 5;

    // Highest index i for which pair (i, i+1) exists; also the final pass number.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        COMPARE = 3'd2,
        SWAP    = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/order_cmp.sv
// ============================================================================
// Module      : order_cmp
// Description : Unsigned out-of-order test for one adjacent pair; ties never swap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module order_cmp
    import sort_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              mode,
    output logic              out_of_order
);

    assign out_of_order = mode ? (a < b) : (a > b);

endmodule

`default_nettype wire

// File: rtl/swap_sort_ctrl.sv
// ============================================================================
// Module      : swap_sort_ctrl
// Description : Bubble-sort sequencer driving an external 8x4 register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swap_sort_ctrl
    import sort_ctrl_pkg::*;
#(
    parameter bit INIT_ON_START = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] rd_x,
    input  logic [DATA_W-1:0] rd_y,
    output logic              init,
    output logic [IDX_W-1:0]  x,
    output logic [IDX_W-1:0]  y,
    output logic              swap,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  swap_count
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_mode;
    logic              w_mode_nxt;
    logic [IDX_W-1:0]  r_pass;
    logic [IDX_W-1:0]  w_pass_nxt;
    logic [IDX_W-1:0]  r_i;
    logic [IDX_W-1:0]  w_i_nxt;
    logic [IDX_W-1:0]  r_y;
    logic [IDX_W-1:0]  w_y_nxt;
    logic              r_swapped;
    logic              w_swapped_nxt;
    logic [CNT_W-1:0]  r_swap_count;
    logic [CNT_W-1:0]  w_swap_count_nxt;

    logic              w_out_of_order;
    logic              w_advance;
    logic              w_pass_swapped;

    order_cmp u_order_cmp (
        .a            (rd_x),
        .b            (rd_y),
        .mode         (r_mode),
        .out_of_order (w_out_of_order)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_mode       <= 1'b0;
            r_pass       <= '0;
            r_i          <= '0;
            r_y          <= '0;
            r_swapped    <= 1'b0;
            r_swap_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_mode       <= w_mode_nxt;
            r_pass       <= w_pass_nxt;
            r_i          <= w_i_nxt;
            r_y          <= w_y_nxt;
            r_swapped    <= w_swapped_nxt;
            r_swap_count <= w_swap_count_nxt;
        end
    end

    // A swap in this cycle counts toward the pass flag before it is registered.
    assign w_pass_swapped = r_swapped | (r_state == SWAP);
    assign w_advance      = ((r_state == COMPARE) && !w_out_of_order) || (r_state == SWAP);

    always_comb begin
        w_state_nxt      = r_state;
        w_mode_nxt       = r_mode;
        w_pass_nxt       = r_pass;
        w_i_nxt          = r_i;
        w_y_nxt          = r_y;
        w_swapped_nxt    = r_swapped;
        w_swap_count_nxt = r_swap_count;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_mode_nxt       = mode;
                    w_pass_nxt       = '0;
                    w_i_nxt          = '0;
                    w_y_nxt          = IDX_W'(1);
                    w_swapped_nxt    = 1'b0;
                    w_swap_count_nxt = '0;
                    w_state_nxt      = INIT_ON_START ? INIT : COMPARE;
                end
            end
            INIT:    w_state_nxt = COMPARE;
            COMPARE: begin
                if (w_out_of_order) begin
                    w_state_nxt = SWAP;
                end
            end
            SWAP: begin
                w_swap_count_nxt = r_swap_count + CNT_W'(1);
                w_swapped_nxt    = 1'b1;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        if (w_advance) begin
            if (r_i < (LAST_IDX - r_pass)) begin
                w_i_nxt     = r_i + IDX_W'(1);
                w_y_nxt     = r_i + IDX_W'(2);
                w_state_nxt = COMPARE;
            end else if (!w_pass_swapped || (r_pass == LAST_IDX)) begin
                w_state_nxt = DONE;
            end else begin
                w_pass_nxt    = r_pass + IDX_W'(1);
                w_i_nxt       = '0;
                w_y_nxt       = IDX_W'(1);
                w_swapped_nxt = 1'b0;
                w_state_nxt   = COMPARE;
            end
        end
    end

    assign init       = (r_state == INIT);
    assign swap       = (r_state == SWAP);
    assign done       = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign x          = r_i;
    assign y          = r_y;
    assign swap_count = r_swap_count;

endmodule

`default_nettype wire
